// File: rtl/phy_tx_pkg.sv
// Shared constants and helpers for the multilane serial transmitter.
// Latency: n/a (package). Backpressure: n/a.
// Contents: default idle symbol, word and slot sizes, lane-width clamp.
package phy_tx_pkg;

  localparam logic [7:0] IDLE_SYM_DEFAULT = 8'hBC;
  localparam int         WORD_W           = 32;
  localparam int         SLOT_LEN         = 32;
  localparam int         CNT_W            = $clog2(SLOT_LEN);

  // Negotiated width to usable lane count: 0 still means one lane,
  // anything wider than the build is limited to the build.
  function automatic int lane_width_clamp(input int req, input int lanes);
    if (req < 1) return 1;
    if (req > lanes) return lanes;
    return req;
  endfunction

endpackage

// File: rtl/phy_lane_ser.sv
// One serial lane: loads a word (data, idle fill or zero) at the slot boundary, shifts out MSB first.
// Latency: loaded word's bit 31 is on ser in the cycle after the load strobe.
// Backpressure: none; the lane consumes whatever it is given on every load strobe.
// Ports: clk_32f/reset clock and async active-low reset; load slot-boundary strobe;
//        enable lane is within the link width; has_data word carries payload;
//        word payload; ser serial bit; active lane carries payload this slot.
module phy_lane_ser
  import phy_tx_pkg::*;
#(
  parameter logic [7:0] IDLE_SYM = IDLE_SYM_DEFAULT
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              load,
  input  logic              enable,
  input  logic              has_data,
  input  logic [WORD_W-1:0] word,
  output logic              ser,
  output logic              active
);

  localparam logic [WORD_W-1:0] IDLE_WORD = {(WORD_W / 8){IDLE_SYM}};

  logic [WORD_W-1:0] shreg;

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      shreg  <= IDLE_WORD;
      active <= 1'b0;
    end else if (load) begin
      if (has_data) begin
        shreg  <= word;
        active <= 1'b1;
      end else if (enable) begin
        shreg  <= IDLE_WORD;
        active <= 1'b0;
      end else begin
        // Lane outside the link width stays quiet for the whole slot.
        shreg  <= '0;
        active <= 1'b0;
      end
    end else begin
      shreg <= {shreg[WORD_W-2:0], 1'b0};
    end
  end

  assign ser = shreg[WORD_W-1];

endmodule

// File: rtl/phy_tx_multilane.sv
// Word FIFO striped across up to LANES serial lanes, one 32-bit word per lane per 32-cycle slot.
// Latency: 1..32 cycles from acceptance to first bit on the wire when the FIFO is otherwise empty.
// Backpressure: ready_out low while the FIFO holds FIFO_DEPTH words; drains up to W words per slot.
// Ports: clk_32f bit clock; reset async active-low; data_in/valid_in/ready_out word input handshake;
//        active_lanes negotiated width (sampled at slot boundary); data_out serial bit per lane;
//        lane_active lane carries a data word in the current slot.
module phy_tx_multilane
  import phy_tx_pkg::*;
#(
  parameter int         LANES      = 2,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] IDLE_SYM   = IDLE_SYM_DEFAULT
) (
  input  logic                    clk_32f,
  input  logic                    reset,
  input  logic [WORD_W-1:0]       data_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  input  logic [$clog2(LANES):0]  active_lanes,
  output logic [LANES-1:0]        data_out,
  output logic [LANES-1:0]        lane_active
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  occ;
  logic              boundary;
  logic              push;
  int                width_eff;
  int                pop_cnt;

  assign boundary  = (cnt == CNT_W'(SLOT_LEN - 1));
  assign ready_out = (occ < OCC_W'(FIFO_DEPTH));
  assign push      = valid_in && ready_out;

  // Pop count uses the occupancy registered before this cycle, so a word
  // written in the boundary cycle waits for the following slot.
  always_comb begin
    width_eff = lane_width_clamp(int'(active_lanes), LANES);
    pop_cnt   = 0;
    if (boundary) begin
      pop_cnt = (int'(occ) < width_eff) ? int'(occ) : width_eff;
    end
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= PTR_W'((int'(wr_ptr) + 1) % FIFO_DEPTH);
      end
      rd_ptr <= PTR_W'((int'(rd_ptr) + pop_cnt) % FIFO_DEPTH);
      occ    <= OCC_W'(int'(occ) + int'(push) - pop_cnt);
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clk_32f) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Lane g takes the g-th oldest word, so lane 0 always gets the oldest.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [PTR_W-1:0] rd_idx;
    assign rd_idx = PTR_W'((int'(rd_ptr) + g) % FIFO_DEPTH);

    phy_lane_ser #(
      .IDLE_SYM (IDLE_SYM)
    ) u_lane (
      .clk_32f  (clk_32f),
      .reset    (reset),
      .load     (boundary),
      .enable   (g < width_eff),
      .has_data (g < pop_cnt),
      .word     (mem[rd_idx]),
      .ser      (data_out[g]),
      .active   (lane_active[g])
    );
  end

endmodule
